// File: rtl/alu_issue_ctrl.sv
// Issue controller feeding arithmetic_logic: decodes one 9-bit math instruction,
// runs the ALU for SETTLE_CYC cycles, captures r_out/s_out and strobes write-back.
// Optional STATUS_FLAGS_EN adds registered zero/equality flags (flag_z, flag_eq).
module alu_issue_ctrl #(
  parameter int SETTLE_CYC = 2,
  parameter int REG_AW     = 3
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_valid,
  input  logic [8:0]        in_instr,
  output logic              in_ready,
  output logic [REG_AW-1:0] rf_ra,
  output logic [REG_AW-1:0] rf_rb,
  input  logic [7:0]        rf_da,
  input  logic [7:0]        rf_db,
  output logic [7:0]        alu_x,
  output logic [7:0]        alu_y,
  output logic [1:0]        alu_math,
  output logic              alu_en,
  output logic              alu_rs,
  input  logic [7:0]        alu_r,
  input  logic [7:0]        alu_s,
  output logic              wb_en,
  output logic [REG_AW-1:0] wb_addr,
  output logic [7:0]        wb_data,
`ifdef STATUS_FLAGS_EN
  output logic              flag_z,
  output logic              flag_eq,
`endif
  output logic [2:0]        dbg_state
);

  localparam logic [2:0] IDLE = 3'd0;
  localparam logic [2:0] READ = 3'd1;
  localparam logic [2:0] EXEC = 3'd2;
  localparam logic [2:0] CAPT = 3'd3;
  localparam logic [2:0] WB   = 3'd4;

  // Handshake: an instruction transfers on a rising edge where in_valid and
  // in_ready are both high; the source holds in_instr stable until then.
  logic [2:0]        r_state;
  logic [8:0]        r_instr;
  logic [3:0]        r_cnt;
  logic [7:0]        r_x;
  logic [7:0]        r_y;
  logic [1:0]        r_math;
  logic              r_rs;
  logic [REG_AW-1:0] r_wb_addr;
  logic [7:0]        r_wb_data;
  logic [7:0]        w_sel;
  logic [7:0]        w_result;

  assign w_sel    = r_rs ? alu_s : alu_r;
  // Equality ops return a single result bit in bit 0.
  assign w_result = r_math[1] ? {7'b0, w_sel[0]} : w_sel;

  assign in_ready  = (r_state == IDLE);
  assign alu_en    = (r_state == EXEC);
  assign wb_en     = (r_state == WB);
  assign rf_ra     = REG_AW'(r_instr[5:3]);
  assign rf_rb     = REG_AW'(r_instr[2:0]);
  assign alu_x     = r_x;
  assign alu_y     = r_y;
  assign alu_math  = r_math;
  assign alu_rs    = r_rs;
  assign wb_addr   = r_wb_addr;
  assign wb_data   = r_wb_data;
  assign dbg_state = r_state;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state   <= IDLE;
      r_instr   <= '0;
      r_cnt     <= '0;
      r_x       <= '0;
      r_y       <= '0;
      r_math    <= '0;
      r_rs      <= 1'b0;
      r_wb_addr <= '0;
      r_wb_data <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (in_valid) begin
            r_instr <= in_instr;
            r_state <= READ;
          end
        end
        READ: begin
          r_x     <= rf_da;
          r_y     <= rf_db;
          r_math  <= r_instr[8:7];
          r_rs    <= r_instr[6];
          r_cnt   <= 4'(SETTLE_CYC - 1);
          r_state <= EXEC;
        end
        EXEC: begin
          if (r_cnt == 4'd0) r_state <= CAPT;
          else               r_cnt   <= r_cnt - 4'd1;
        end
        CAPT: begin
          r_wb_data <= w_result;
          r_wb_addr <= REG_AW'(r_instr[5:3]);
          r_state   <= WB;
        end
        WB:      r_state <= IDLE;
        default: r_state <= IDLE;
      endcase
    end
  end

`ifdef STATUS_FLAGS_EN
  logic r_flag_z;
  logic r_flag_eq;

  // Flags load alongside wb_data so they are valid during the WB strobe.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_flag_z  <= 1'b0;
      r_flag_eq <= 1'b0;
    end else if (r_state == CAPT) begin
      r_flag_z <= (w_result == 8'd0);
      if (r_math[1]) r_flag_eq <= w_result[0];
    end
  end

  assign flag_z  = r_flag_z;
  assign flag_eq = r_flag_eq;
`endif

endmodule

// File: tb/tb_alu_issue_ctrl.sv
// Directed bench for alu_issue_ctrl: register-file and ALU models, scoreboard
// queue of hand-computed write-backs, and a monitor that checks every wb_en.
module tb_alu_issue_ctrl;
  localparam int SETTLE_CYC = 2;

  logic       clk;
  logic       reset;
  logic       in_valid;
  logic [8:0] in_instr;
  logic       in_ready;
  logic [2:0] rf_ra, rf_rb;
  logic [7:0] rf_da, rf_db;
  logic [7:0] alu_x, alu_y;
  logic [1:0] alu_math;
  logic       alu_en, alu_rs;
  logic [7:0] alu_r, alu_s;
  logic       wb_en;
  logic [2:0] wb_addr;
  logic [7:0] wb_data;
  logic [2:0] dbg_state;
`ifdef STATUS_FLAGS_EN
  logic       flag_z, flag_eq;
`endif

  alu_issue_ctrl #(.SETTLE_CYC(SETTLE_CYC), .REG_AW(3)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_instr(in_instr),
    .in_ready(in_ready), .rf_ra(rf_ra), .rf_rb(rf_rb), .rf_da(rf_da), .rf_db(rf_db),
    .alu_x(alu_x), .alu_y(alu_y), .alu_math(alu_math), .alu_en(alu_en),
    .alu_rs(alu_rs), .alu_r(alu_r), .alu_s(alu_s), .wb_en(wb_en),
    .wb_addr(wb_addr), .wb_data(wb_data),
`ifdef STATUS_FLAGS_EN
    .flag_z(flag_z), .flag_eq(flag_eq),
`endif
    .dbg_state(dbg_state)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- register file and ALU models ----------------
  logic [7:0] regs [8];
  assign rf_da = regs[rf_ra];
  assign rf_db = regs[rf_rb];

  function automatic logic [7:0] alu_f(input logic [7:0] x, input logic [7:0] y,
                                       input logic [1:0] m);
    case (m)
      2'd0:    alu_f = x + y;
      2'd1:    alu_f = x - y;
      2'd2:    alu_f = {7'b0, x == y};
      default: alu_f = {7'b0, x[4:0] == y[4:0]};
    endcase
  endfunction

  // Only the selected output latch updates, so a wrong select reads stale data.
  initial begin
    alu_r = 8'h00;
    alu_s = 8'h00;
  end
  always @(posedge clk) begin
    if (alu_en) begin
      if (alu_rs) alu_s <= alu_f(alu_x, alu_y, alu_math);
      else        alu_r <= alu_f(alu_x, alu_y, alu_math);
    end
  end

  // ---------------- scoreboard ----------------
  // entry: {chk_eq, eq, z, addr[2:0], data[7:0]}
  logic [13:0] exp_q[$];
  int          acc_q[$];
  int          n_pass = 0;
  int          n_chk  = 0;
  bit          stream = 1'b0;
  int          n_wb   = 0;
  int          last_wb = -1;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
  endtask

  function automatic logic [13:0] mk(input logic [2:0] a, input logic [7:0] d,
                                     input logic z, input logic ce, input logic eq);
    mk = {ce, eq, z, a, d};
  endfunction

  always @(negedge clk) begin
    if (!reset && wb_en) begin
      n_wb++;
      if (exp_q.size() == 0) begin
        chk("unexpected_wb", {29'b0, wb_addr}, 32'hFFFF_FFFF);
      end else begin
        logic [13:0] e;
        int          t;
        e = exp_q.pop_front();
        t = acc_q.pop_front();
        chk("wb_addr", {29'b0, wb_addr}, {29'b0, e[10:8]});
        chk("wb_data", {24'b0, wb_data}, {24'b0, e[7:0]});
        chk("latency", cyc - t + 1, SETTLE_CYC + 3);
`ifdef STATUS_FLAGS_EN
        chk("flag_z", {31'b0, flag_z}, {31'b0, e[11]});
        if (e[13]) chk("flag_eq", {31'b0, flag_eq}, {31'b0, e[12]});
`endif
        if (stream && last_wb >= 0) chk("wb_spacing", cyc - last_wb, SETTLE_CYC + 4);
        last_wb = cyc;
      end
    end
  end

  // ---------------- driver tasks ----------------
  // Raises in_valid with ins and returns #1 after the accepting edge, in_valid still high.
  task automatic issue(input logic [8:0] ins, input logic [13:0] exp, input bit expect_wb);
    int n;
    in_instr = ins;
    in_valid = 1'b1;
    n = 0;
    while (!in_ready && n < 50) begin
      @(posedge clk); #1;
      n++;
    end
    if (n >= 50) chk("accept_timeout", 32'd0, 32'd1);
    @(posedge clk); #1;
    if (expect_wb) begin
      exp_q.push_back(exp);
      acc_q.push_back(cyc);
    end
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while ((exp_q.size() != 0 || !in_ready) && n < 100) begin
      @(posedge clk); #1;
      n++;
    end
    if (n >= 100) chk("idle_timeout", 32'd0, 32'd1);
  endtask

  task automatic wait_en();
    int n;
    n = 0;
    while (!alu_en && n < 20) begin
      @(posedge clk); #1;
      n++;
    end
    if (n >= 20) chk("alu_en_timeout", 32'd0, 32'd1);
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    reset    = 1'b1;
    in_valid = 1'b0;
    in_instr = 9'd0;
    regs[0] = 8'h25; regs[1] = 8'h05; regs[2] = 8'h7F; regs[3] = 8'h01;
    regs[4] = 8'h07; regs[5] = 8'h05; regs[6] = 8'hFF; regs[7] = 8'h01;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_in_ready", {31'b0, in_ready}, 32'd1);
    chk("rst_alu_en",   {31'b0, alu_en},   32'd0);
    chk("rst_wb_en",    {31'b0, wb_en},    32'd0);
    chk("rst_alu_x",    {24'b0, alu_x},    32'd0);
    chk("rst_wb_data",  {24'b0, wb_data},  32'd0);
    chk("rst_state",    {29'b0, dbg_state}, 32'd0);
    @(negedge clk) reset = 1'b0;
    @(posedge clk); #1;

    // add r2+r3 -> r2 = 0x80
    issue(9'b00_0_010_011, mk(3'd2, 8'h80, 1'b0, 1'b0, 1'b0), 1'b1);
    in_valid = 1'b0;
    wait_idle();

    // sub r1-r4 into s_out -> 0xFE
    issue(9'b01_1_001_100, mk(3'd1, 8'hFE, 1'b0, 1'b0, 1'b0), 1'b1);
    in_valid = 1'b0;
    wait_en();
    chk("sub_alu_rs",   {31'b0, alu_rs},   32'd1);
    chk("sub_alu_math", {30'b0, alu_math}, 32'd1);
    chk("sub_alu_x",    {24'b0, alu_x},    32'h05);
    chk("sub_alu_y",    {24'b0, alu_y},    32'h07);
    wait_idle();
    chk("hold_alu_y",   {24'b0, alu_y},    32'h07);

    // eql5 / eql8 on r0=0x25, r5=0x05
    issue(9'b11_0_000_101, mk(3'd0, 8'h01, 1'b0, 1'b1, 1'b1), 1'b1);
    in_valid = 1'b0;
    wait_idle();
    issue(9'b10_0_000_101, mk(3'd0, 8'h00, 1'b1, 1'b1, 1'b0), 1'b1);
    in_valid = 1'b0;
    wait_idle();

    // in_valid held high across three instructions
    stream  = 1'b1;
    n_wb    = 0;
    last_wb = -1;
    issue(9'b00_0_010_011, mk(3'd2, 8'h80, 1'b0, 1'b0, 1'b0), 1'b1);
    issue(9'b01_0_001_100, mk(3'd1, 8'hFE, 1'b0, 1'b0, 1'b0), 1'b1);
    issue(9'b11_0_000_101, mk(3'd0, 8'h01, 1'b0, 1'b1, 1'b1), 1'b1);
    in_valid = 1'b0;
    wait_idle();
    repeat (3) @(posedge clk);
    #1;
    chk("stream_wb_count", n_wb, 3);
    stream = 1'b0;

    // reset mid-EXEC aborts without a write-back
    issue(9'b00_0_010_011, 14'd0, 1'b0);
    in_valid = 1'b0;
    wait_en();
    @(negedge clk) reset = 1'b1;
    #1;
    chk("abort_in_ready", {31'b0, in_ready}, 32'd1);
    chk("abort_alu_en",   {31'b0, alu_en},   32'd0);
    @(posedge clk); #1;
    chk("abort_state",    {29'b0, dbg_state}, 32'd0);
    chk("abort_wb_en",    {31'b0, wb_en},    32'd0);
    @(negedge clk) reset = 1'b0;
    n_wb = 0;
    repeat (12) @(posedge clk);
    #1;
    chk("abort_no_wb", n_wb, 0);

    // add 0xFF+0x01 -> 0x00 (zero flag), then eql8 r6,r6 -> 1
    issue(9'b00_0_110_111, mk(3'd6, 8'h00, 1'b1, 1'b0, 1'b0), 1'b1);
    in_valid = 1'b0;
    wait_idle();
    issue(9'b10_0_110_110, mk(3'd6, 8'h01, 1'b0, 1'b1, 1'b1), 1'b1);
    in_valid = 1'b0;
    wait_idle();

    repeat (4) @(posedge clk);
    #1;
    chk("queue_drained", exp_q.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
